// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the UART program loader.
//   loader_state_t   - FSM state encoding used by uart_loader
//   DEFAULT_ACK_BYTE - byte returned after a successful load
//   DEFAULT_NAK_BYTE - byte returned when the declared size does not fit
package loader_pkg;

    typedef enum logic [2:0] {
        S_SIZE,
        S_DATA,
        S_ACK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'hEE;

endpackage

// File: rtl/uart_loader_byte_packer.sv
// byte_packer: assembles 32-bit words from a little-endian byte stream.
//   clk, rst - clock and asynchronous active-high reset
//   en       - a byte is presented on din and consumed this cycle
//   din      - incoming byte
//   word     - assembled word, meaningful in the cycle done is high
//   done     - high in the cycle the 4th byte of a word is consumed
// The first three bytes are held in a shift register; the fourth byte is
// merged combinationally so the consumer can act on the word in the same
// cycle it completes.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        done
);

    logic [1:0]  idx;
    logic [23:0] low;   // bytes 2..0 of the word in progress, newest on top

    assign word = {din, low};
    assign done = en && (idx == 2'd3);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (en) begin
            idx <= idx + 2'd1;
            low <= {din, low[23:8]};
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: receives a program over a byte FIFO and writes it into
// instruction memory, then releases the CPU.
// Protocol: 4-byte little-endian word count N, then N little-endian words.
//   clk, rst                  - clock, asynchronous active-high reset
//   rx_data, rx_empty         - first-word-fall-through receive FIFO head
//   rx_rd_en                  - pops the receive FIFO
//   tx_data, tx_full,tx_wr_en - transmit FIFO push interface (ACK / NAK)
//   imem_we, imem_addr,
//   imem_wdata                - instruction-memory write port
//   cpu_start                 - CPU release level after a successful load
//   busy                      - load in progress
//   err                       - sticky size-overflow flag
module uart_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W   = 14,
    parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE = DEFAULT_NAK_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_rd_en,
    output logic [7:0]        tx_data,
    input  logic              tx_full,
    output logic              tx_wr_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              err
);

    localparam int          CNT_W    = ADDR_W + 1;
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    loader_state_t    state;
    logic [31:0]      size_n;
    logic [CNT_W-1:0] word_cnt;     // one extra bit so N = 2^ADDR_W cannot wrap
    logic [CNT_W-1:0] word_cnt_nxt;
    logic             nak_sent;
    logic [31:0]      pk_word;
    logic             pk_done;

    // The pop strobe is the only combinational output: the FIFO head is
    // consumed in the same cycle it is seen.
    assign rx_rd_en     = !rst && !rx_empty && ((state == S_SIZE) || (state == S_DATA));
    assign word_cnt_nxt = word_cnt + 1'b1;

    // Size and data bytes share one packer; the size phase consumes exactly
    // four bytes, so the byte index is already aligned for the first word.
    byte_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .en   (rx_rd_en),
        .din  (rx_data),
        .word (pk_word),
        .done (pk_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_SIZE;
            size_n     <= 32'd0;
            word_cnt   <= '0;
            nak_sent   <= 1'b0;
            tx_data    <= 8'd0;
            tx_wr_en   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we  <= 1'b0;
            tx_wr_en <= 1'b0;
            case (state)
                S_SIZE: begin
                    if (rx_rd_en) begin
                        busy <= 1'b1;
                    end
                    if (pk_done) begin
                        size_n <= pk_word;
                        if (pk_word == 32'd0) begin
                            state <= S_ACK;
                        end else if ({1'b0, pk_word} > CAPACITY) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (pk_done) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= pk_word;
                        word_cnt   <= word_cnt_nxt;
                        // Leave on the last byte so no extra byte is popped
                        // while the final write is being issued.
                        if (32'(word_cnt_nxt) == size_n) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (!tx_full) begin
                        tx_wr_en  <= 1'b1;
                        tx_data   <= ACK_BYTE;
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        cpu_start <= 1'b1;
                    end
                end
                S_DONE: begin
                    cpu_start <= 1'b1;
                end
                S_ERR: begin
                    if (!nak_sent && !tx_full) begin
                        tx_wr_en <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        nak_sent <= 1'b1;
                    end
                end
                default: begin
                    state <= S_SIZE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter ADDR_W, default 14: instruction-memory word-address width; capacity is 2^ADDR_W words.
REQ-002 Parameter ACK_BYTE, default 8'hAA: byte sent after a successful load.
REQ-003 Parameter NAK_BYTE, default 8'hEE: byte sent when the declared size exceeds capacity.
REQ-004 clk  in  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 rx_data  in  8: head byte of the receive FIFO; first-word-fall-through, valid whenever rx_empty=0.
REQ-007 rx_empty  in  1: receive FIFO empty.
REQ-008 rx_rd_en  out  1: pops one byte from the receive FIFO in the cycle it is high.
REQ-009 tx_data  out  8: byte to the transmit FIFO.
REQ-010 tx_full  in  1: transmit FIFO full.
REQ-011 tx_wr_en  out  1: pushes tx_data into the transmit FIFO in the cycle it is high.
REQ-012 imem_we  out  1: instruction-memory write strobe, one cycle per word.
REQ-013 imem_addr  out  ADDR_W: word address.
REQ-014 imem_wdata  out  32: word data.
REQ-015 cpu_start  out  1: level signal that releases the CPU from hold.
REQ-016 busy  out  1: high while a load is in progress.
REQ-017 err  out  1: sticky size-overflow flag.

Function
REQ-018 The FSM SHALL have exactly five states: S_SIZE, S_DATA, S_ACK, S_DONE, S_ERR.
REQ-019 rx_rd_en SHALL equal !rx_empty in S_SIZE and S_DATA, and SHALL be 0 in all other states; a byte is consumed in each cycle where rx_rd_en=1.
REQ-020 S_SIZE SHALL collect 4 bytes little-endian (first byte to bits 7:0) into a 32-bit word count N.
REQ-021 On the 4th size byte, the FSM SHALL go to S_ACK if N=0, to S_ERR if N>2^ADDR_W, and to S_DATA otherwise.
REQ-022 S_DATA SHALL assemble 4 bytes little-endian per word.
REQ-023 Each completed word SHALL produce imem_we=1 in the cycle after its 4th byte is consumed, with imem_addr set to the word index (0, 1, ... N-1) and imem_wdata set to the assembled word.
REQ-024 Byte collection SHALL continue in the same cycle as an imem_we pulse; no bubble is required.
REQ-025 After the write of word N-1, the FSM SHALL enter S_ACK.
REQ-026 The word counter SHALL be ADDR_W+1 bits wide, so that N=2^ADDR_W loads without wrap-around.
REQ-027 S_ACK SHALL hold tx_data=ACK_BYTE and assert tx_wr_en for exactly one cycle, in the first cycle with tx_full=0; the FSM SHALL then enter S_DONE.
REQ-028 While tx_full=1 in S_ACK, the FSM SHALL wait with tx_wr_en=0.
REQ-029 S_DONE SHALL assert cpu_start=1 and remain in S_DONE until reset; further RX bytes SHALL NOT be consumed.
REQ-030 S_ERR SHALL set err=1 and send NAK_BYTE once, under the same tx_full rule as S_ACK.
REQ-031 S_ERR SHALL then remain in S_ERR until reset, with cpu_start=0 and no RX consumption.
REQ-032 busy SHALL be 1 in S_SIZE once at least one byte has been consumed, in S_DATA and in S_ACK; it SHALL be 0 otherwise.
REQ-033 All outputs except rx_rd_en SHALL be driven from registers.
REQ-034 rx_empty=1 mid-word SHALL stall byte collection without losing the partially assembled bytes.

Reset
REQ-035 While rst=1: state=S_SIZE, byte index=0, word counter=0, N=0, and outputs rx_rd_en, tx_wr_en, imem_we, cpu_start, busy and err all 0.
REQ-036 While rst=1, tx_data, imem_addr and imem_wdata SHALL be 0.
REQ-037 Reset asserted mid-load SHALL abort the load immediately; the next byte after release is treated as size byte 0.
REQ-038 No partial imem_we SHALL occur across a reset.

Structure
REQ-039 Package loader_pkg SHALL hold the state enum loader_state_t and the default ACK/NAK byte constants.
REQ-040 A sub-module byte_packer (4-byte little-endian shift-assembler with a done pulse) SHALL be used for both size and data collection.
REQ-041 The implementation SHALL stay within 120-400 lines of RTL.

Verification
REQ-042 Bytes 01 00 00 00 EF BE AD DE -> one imem_we: addr 0, data 32'hDEADBEEF; then tx byte AA; then cpu_start=1.
REQ-043 Size bytes 00 00 00 00 -> no imem_we; tx byte AA; cpu_start=1.
REQ-044 Size 2 with rx_empty pulsed high between every byte, and tx_full=1 held for 5 cycles in S_ACK -> writes to addr 0 then addr 1 with correct data; tx_wr_en occurs once, in the first cycle with tx_full=0.
REQ-045 With ADDR_W=4, size 17 -> err=1; tx byte EE once; cpu_start=0; no imem_we; later RX bytes are not popped.
REQ-046 With ADDR_W=4, size 16 -> 16 writes to addr 0 through 15; addr does not wrap; ACK is sent.
REQ-047 rst asserted after 2 data bytes, then bytes 01 00 00 00 78 56 34 12 -> single write: addr 0, data 32'h12345678.
